qam_bit_sched: RTL and testbench
================================

Name: qam_bit_sched

Overview:
- Scheduler/controller for the serial bit source (data generator, `adat_ki` output).
- Paces the generator with a programmable bit-rate strobe and collects BITS_PER_SYM consecutive bits into one QAM symbol.
- Presents each symbol to the mapper with a valid/ready handshake and stalls the generator while the mapper is not ready.
- Tracks frame boundaries for the downstream modulator.

Parameters:
- BITS_PER_SYM, 4, bits per QAM symbol (4 = 16-QAM); legal range 1..8.
- DIV_W, 8, width of the bit-rate divider input.
- FRAME_LEN, 64, symbols per frame; must be ≥1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- enable  in  1  level; 1 = run the source, 0 = stop at the next symbol boundary.
- div  in  DIV_W  clock cycles per bit minus 1; latched at each entry to FILL.
- gen_en  out  1  one-cycle strobe that advances the data generator to its next bit.
- adat_ki  in  1  current generator bit; sampled only in cycles where gen_en=1.
- sym_data  out  BITS_PER_SYM  assembled symbol; first received bit is the MSB.
- sym_valid  out  1  symbol available; held until accepted.
- sym_ready  in  1  mapper accepts sym_data when sym_valid & sym_ready.
- frame_start  out  1  qualifies sym_valid; 1 for symbol index 0 of a frame.
- busy  out  1  1 whenever state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; divider count, bit count and frame count = 0; shift register = 0.
  - Outputs: gen_en=0, sym_valid=0, sym_data=0, frame_start=0, busy=0.
  - A partially collected symbol is discarded.
  - First action after release is evaluated on the first clock edge.
- States:
  - IDLE: gen_en=0, sym_valid=0, frame count=0.
    - If enable=1 at an edge: go to FILL, div_q<=div, divider count<=0, bit count<=0.
  - FILL: divider counts 0..div_q.
    - gen_en = (state==FILL) & (divider count==div_q); it is decoded from registers.
    - In a gen_en cycle: shift register <= {shift[BITS_PER_SYM-2:0], adat_ki}, divider count<=0, bit count++.
    - On the BITS_PER_SYM-th gen_en: load sym_data with the completed symbol, set sym_valid=1 and frame_start=(frame count==0), go to VALID.
    - sym_valid therefore rises exactly 1 cycle after the last gen_en.
    - div_q=0 gives gen_en on every FILL cycle. div_q=N gives one strobe every N+1 cycles; the first strobe comes N+1 cycles after entering FILL.
  - VALID: gen_en=0; sym_data, sym_valid and frame_start are held stable until handshake.
    - On handshake: sym_valid<=0, frame_start<=0.
    - Frame count wraps to 0 when it reaches FRAME_LEN-1; otherwise it increments.
    - After the handshake: if enable=1, go to FILL (div re-latched, counts cleared); else go to IDLE.
    - sym_ready is ignored while sym_valid=0.
- enable=0 during FILL has no immediate effect. The current symbol completes and is delivered, and the FSM stops only after its handshake. No partial symbols are ever emitted.
- A new run always starts a new frame, because frame count is cleared in IDLE.
- Minimum symbol period: BITS_PER_SYM*(div_q+1)+1 cycles with sym_ready held at 1.
- Generator bits are never skipped or duplicated: exactly BITS_PER_SYM gen_en pulses per delivered symbol.

Optional Feature:
- Macro QAM_BIT_SCHED_SYMCNT_EN.
- When defined:
  - Adds output sym_cnt (16 bits), the count of accepted handshakes.
  - It saturates at 16'hFFFF, is cleared only by reset, and is not cleared by IDLE.
  - Updates on the same edge as the handshake.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Case 1, single symbol:
  - Stimulus: BITS_PER_SYM=4, div=0, sym_ready=1, enable pulsed high for 1 cycle, generator bits 1,0,1,1.
  - Required: 4 consecutive gen_en pulses, then sym_data=4'b1011 and sym_valid=1 for 1 cycle with frame_start=1; then IDLE with busy=0.
- Case 2, divider:
  - Stimulus: div=3, enable held at 1.
  - Required: gen_en spacing of exactly 4 cycles; sym_valid every 17 cycles; changing div to 1 mid-symbol has no effect until the next FILL.
- Case 3, backpressure:
  - Stimulus: sym_ready=0 for 10 cycles after sym_valid rises.
  - Required: sym_data and sym_valid stable, no gen_en pulses; the handshake completes the cycle sym_ready=1, and FILL resumes.
- Case 4, frame wrap:
  - Stimulus: FRAME_LEN=3, 7 symbols streamed.
  - Required: frame_start=1 on symbols 0, 3 and 6 only.
- Case 5, stop and reset mid-operation:
  - Stimulus and required response:
    - Drop enable after 2 bits: 2 more gen_en pulses, the symbol is delivered, then IDLE.
    - Assert reset after 2 bits: outputs go to 0 immediately, with no symbol delivered.
    - Re-enable: frame_start=1 on the next symbol.
- Case 6, SYMCNT_EN:
  - Stimulus: 5 handshakes, then one IDLE period, then 2 more.
  - Required: sym_cnt=7; a forced count of 16'hFFFF plus one handshake stays at 16'hFFFF.

Source files
------------

// File: rtl/qam_bit_sched.sv
// qam_bit_sched: paces a serial bit generator with a programmable bit-rate
// strobe, packs BITS_PER_SYM bits (first bit = MSB) into one QAM symbol,
// presents it to the mapper over valid/ready and tracks frame boundaries.
//
// Ports:
//   clock, reset    - system clock, asynchronous active-low reset
//   enable          - run request; a stop takes effect only after a handshake
//   div             - clock cycles per bit minus 1, latched on each FILL entry
//   gen_en          - one-cycle strobe advancing the generator
//   adat_ki         - generator bit, sampled when gen_en=1
//   sym_data/sym_valid/sym_ready - symbol handshake to the mapper
//   frame_start     - marks symbol index 0 of a frame (qualified by sym_valid)
//   busy            - state is not IDLE
//   sym_cnt         - saturating count of accepted symbols
//                     (only with QAM_BIT_SCHED_SYMCNT_EN defined)
module qam_bit_sched #(
    parameter int unsigned BITS_PER_SYM = 4,
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned FRAME_LEN    = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        div,
    output logic                    gen_en,
    input  logic                    adat_ki,
    output logic [BITS_PER_SYM-1:0] sym_data,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    frame_start,
`ifdef QAM_BIT_SCHED_SYMCNT_EN
    output logic [15:0]             sym_cnt,
`endif
    output logic                    busy
);

    localparam int unsigned BCNT_W = (BITS_PER_SYM > 1) ? $clog2(BITS_PER_SYM) : 1;
    localparam int unsigned FCNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_VALID = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
    logic [BCNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [FCNT_W-1:0]       frame_cnt_q, frame_cnt_d;
    logic [BITS_PER_SYM-1:0] shift_q, shift_d;
    logic [BITS_PER_SYM-1:0] sym_data_q, sym_data_d;
    logic                    frame_start_q, frame_start_d;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
    logic [15:0]             sym_cnt_q, sym_cnt_d;
`endif

    logic strobe;
    logic last_bit;
    logic [BITS_PER_SYM-1:0] shifted;

    // Bit strobe decoded straight from registers: last count of the divider
    assign strobe   = (state_q == ST_FILL) && (div_cnt_q == div_q);
    assign last_bit = (bit_cnt_q == BCNT_W'(BITS_PER_SYM - 1));
    // Shift in the new bit; the cast drops the oldest bit (also covers 1-bit symbols)
    assign shifted  = BITS_PER_SYM'({shift_q, adat_ki});

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            div_cnt_q     <= '0;
            bit_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            shift_q       <= '0;
            sym_data_q    <= '0;
            frame_start_q <= 1'b0;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
            sym_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            div_cnt_q     <= div_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            shift_q       <= shift_d;
            sym_data_q    <= sym_data_d;
            frame_start_q <= frame_start_d;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
            sym_cnt_q     <= sym_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        div_d         = div_q;
        div_cnt_d     = div_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        shift_d       = shift_q;
        sym_data_d    = sym_data_q;
        frame_start_d = frame_start_q;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
        sym_cnt_d     = sym_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // A new run always begins a new frame
                frame_cnt_d = '0;
                if (enable) begin
                    state_d   = ST_FILL;
                    div_d     = div;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                end
            end
            ST_FILL: begin
                if (strobe) begin
                    shift_d   = shifted;
                    div_cnt_d = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (last_bit) begin
                        state_d       = ST_VALID;
                        bit_cnt_d     = '0;
                        sym_data_d    = shifted;
                        frame_start_d = (frame_cnt_q == '0);
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            ST_VALID: begin
                if (sym_ready) begin
                    frame_start_d = 1'b0;
                    frame_cnt_d   = (frame_cnt_q == FCNT_W'(FRAME_LEN - 1)) ? '0
                                                                            : frame_cnt_q + 1'b1;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
                    if (sym_cnt_q != 16'hFFFF) begin
                        sym_cnt_d = sym_cnt_q + 16'd1;
                    end
`endif
                    if (enable) begin
                        state_d   = ST_FILL;
                        div_d     = div;
                        div_cnt_d = '0;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        gen_en      = strobe;
        sym_valid   = (state_q == ST_VALID);
        sym_data    = sym_data_q;
        frame_start = frame_start_q;
        busy        = (state_q != ST_IDLE);
`ifdef QAM_BIT_SCHED_SYMCNT_EN
        sym_cnt     = sym_cnt_q;
`endif
    end

endmodule

// File: tb/tb_qam_bit_sched.sv
// Testbench for qam_bit_sched: directed scenarios plus a schedule-based
// reference model checked on every falling clock edge.
// Build with QAM_BIT_SCHED_SYMCNT_EN defined to also exercise sym_cnt.
module tb_qam_bit_sched;

    localparam int BPS = 4;
    localparam int DW  = 8;
    localparam int FL  = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] div;
    logic          gen_en;
    logic          adat_ki;
    logic [BPS-1:0] sym_data;
    logic          sym_valid;
    logic          sym_ready;
    logic          frame_start;
    logic          busy;
`ifdef QAM_BIT_SCHED_SYMCNT_EN
    logic [15:0]   sym_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] mcnt = '0;

    // Serial bit source: fixed pattern, advanced by gen_en
    logic [31:0] pat = 32'b1011_0100_1110_0011_0101_1001_0010_1111;
    int gptr = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && gen_en) gptr <= (gptr + 1) % 32;
    end
    assign adat_ki = pat[5'(31 - gptr)];

    qam_bit_sched #(
        .BITS_PER_SYM(BPS),
        .DIV_W       (DW),
        .FRAME_LEN   (FL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .div        (div),
        .gen_en     (gen_en),
        .adat_ki    (adat_ki),
        .sym_data   (sym_data),
        .sym_valid  (sym_valid),
        .sym_ready  (sym_ready),
        .frame_start(frame_start),
`ifdef QAM_BIT_SCHED_SYMCNT_EN
        .sym_cnt    (sym_cnt),
`endif
        .busy       (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Steps until sym_valid is seen; reports cycles taken and gen_en pulses before it
    task automatic wait_valid(input int chg_at, input logic [DW-1:0] nd,
                              output int c, output int g);
        bit seen = 1'b0;
        c = 0;
        g = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            step();
            c = i;
            if (i == chg_at) div = nd;
            if (sym_valid) seen = 1'b1;
            else if (gen_en) g++;
        end
        if (!seen) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_valid: sym_valid not seen within %0d cycles", c);
        end
    endtask

    // Streams n symbols with sym_ready=1, dropping enable before the last handshake
    task automatic run_syms(input int n);
        int c, g;
        enable = 1'b1;
        for (int i = 0; i < n; i++) begin
            wait_valid(-1, div, c, g);
            if (i == n - 1) enable = 1'b0;
        end
        step();
    endtask

    // Reference model: each symbol of a run occupies BPS*(div+1) fill cycles
    // starting at t0; strobes land on the last cycle of each (div+1) slot and
    // the symbol is offered from then until accepted.
    task automatic monitor();
        int cyc = 0;
        int t0 = 0;
        int mdiv = 0;
        int p, rel;
        int frame = 0;
        bit run = 1'b0;
        bit e_gen, e_val;
        logic [BPS-1:0] msym = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                run   = 1'b0;
                frame = 0;
                msym  = '0;
                mcnt  = '0;
                chk("rst_gen_en", 32'(gen_en), 0);
                chk("rst_sym_valid", 32'(sym_valid), 0);
                chk("rst_sym_data", 32'(sym_data), 0);
                chk("rst_frame_start", 32'(frame_start), 0);
                chk("rst_busy", 32'(busy), 0);
`ifdef QAM_BIT_SCHED_SYMCNT_EN
                chk("rst_sym_cnt", 32'(sym_cnt), 0);
`endif
            end else begin
                p     = mdiv + 1;
                rel   = cyc - t0;
                e_gen = run && (rel < BPS * p) && ((rel % p) == p - 1);
                e_val = run && (rel >= BPS * p);
                chk("gen_en", 32'(gen_en), 32'(e_gen));
                chk("sym_valid", 32'(sym_valid), 32'(e_val));
                chk("busy", 32'(busy), 32'(run));
                chk("frame_start", 32'(frame_start), 32'(e_val && frame == 0));
                if (e_val) chk("sym_data", 32'(sym_data), 32'(msym));
`ifdef QAM_BIT_SCHED_SYMCNT_EN
                chk("sym_cnt", 32'(sym_cnt), 32'(mcnt));
`endif
                if (!run) begin
                    if (enable) begin
                        run  = 1'b1;
                        t0   = cyc + 1;
                        mdiv = int'(div);
                        msym = '0;
                    end
                end else if (e_gen) begin
                    msym = {msym[BPS-2:0], adat_ki};
                end else if (e_val && sym_ready) begin
                    frame = (frame + 1) % FL;
                    if (mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
                    if (enable) begin
                        t0   = cyc + 1;
                        mdiv = int'(div);
                        msym = '0;
                    end else begin
                        run   = 1'b0;
                        frame = 0;
                    end
                end
            end
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, g, n;
        logic [BPS-1:0] held;
        int exp_fs[7] = '{1, 0, 0, 1, 0, 0, 1};

        reset     = 1'b1;
        enable    = 1'b0;
        div       = '0;
        sym_ready = 1'b1;
        fork
            monitor();
        join_none
        #2;
        reset = 1'b0;
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_sym_valid", 32'(sym_valid), 0);
        chk("reset_gen_en", 32'(gen_en), 0);
        repeat (3) step();
        reset = 1'b1;

        // Case 1: one-cycle enable pulse, div=0, bits 1,0,1,1
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("c1_first_gen_en", 32'(gen_en), 1);
        wait_valid(-1, div, c, g);
        chk("c1_latency", c, 4);
        chk("c1_gen_pulses", g + 1, 4);
        chk("c1_sym_data", 32'(sym_data), 32'hB);
        chk("c1_frame_start", 32'(frame_start), 1);
        step();
        chk("c1_idle_busy", 32'(busy), 0);
        chk("c1_idle_valid", 32'(sym_valid), 0);

        // Case 2: div=3, enable held; div change mid-symbol applies next symbol
        div    = 8'd3;
        enable = 1'b1;
        wait_valid(-1, div, c, g);
        chk("c2_first_latency", c, 17);
        chk("c2_first_pulses", g, 4);
        wait_valid(-1, div, c, g);
        chk("c2_period", c, 17);
        wait_valid(5, 8'd1, c, g);
        chk("c2_period_div_changed", c, 17);
        chk("c2_pulses_div_changed", g, 4);
        wait_valid(-1, div, c, g);
        chk("c2_period_div1", c, 9);

        // Case 3: backpressure for 10 cycles
        wait_valid(-1, div, c, g);
        sym_ready = 1'b0;
        held = sym_data;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("c3_valid_held", 32'(sym_valid), 1);
            chk("c3_data_held", 32'(sym_data), 32'(held));
            chk("c3_no_gen_en", 32'(gen_en), 0);
        end
        sym_ready = 1'b1;
        step();
        chk("c3_after_hs_valid", 32'(sym_valid), 0);
        chk("c3_after_hs_busy", 32'(busy), 1);
        wait_valid(-1, div, c, g);
        chk("c3_resume_latency", c, 8);
        chk("c3_resume_pulses", g, 4);
        enable = 1'b0;
        step();
        chk("c3_stop_busy", 32'(busy), 0);

        // Case 4: frame wrap with FRAME_LEN=3 over 7 symbols
        div    = 8'd0;
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            wait_valid(-1, div, c, g);
            chk($sformatf("c4_frame_start_%0d", i), 32'(frame_start), 32'(exp_fs[i]));
            if (i == 6) enable = 1'b0;
        end
        step();
        chk("c4_idle_busy", 32'(busy), 0);

        // Case 5a: drop enable after 2 bits; symbol still completes
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            step();
            if (gen_en) n++;
        end
        enable = 1'b0;
        wait_valid(-1, div, c, g);
        chk("c5_remaining_pulses", g, 2);
        chk("c5_delivered", 32'(sym_valid), 1);
        step();
        chk("c5_stop_busy", 32'(busy), 0);

        // Case 5b: reset after 2 bits of the second symbol, then restart
        enable = 1'b1;
        wait_valid(-1, div, c, g);
        chk("c5_sym0_frame_start", 32'(frame_start), 1);
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            step();
            if (gen_en) n++;
        end
        reset = 1'b0;
        #1;
        chk("c5_rst_busy", 32'(busy), 0);
        chk("c5_rst_gen_en", 32'(gen_en), 0);
        chk("c5_rst_valid", 32'(sym_valid), 0);
        chk("c5_rst_data", 32'(sym_data), 0);
        chk("c5_rst_frame_start", 32'(frame_start), 0);
        step();
        step();
        reset = 1'b1;
        wait_valid(-1, div, c, g);
        chk("c5_restart_latency", c, 5);
        chk("c5_restart_frame_start", 32'(frame_start), 1);
        enable = 1'b0;
        step();

`ifdef QAM_BIT_SCHED_SYMCNT_EN
        // Case 6: handshake counter survives IDLE and saturates
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("c6_cnt_reset", 32'(sym_cnt), 0);
        run_syms(5);
        repeat (4) step();
        chk("c6_idle_busy", 32'(busy), 0);
        chk("c6_cnt_5", 32'(sym_cnt), 5);
        run_syms(2);
        chk("c6_cnt_7", 32'(sym_cnt), 7);
        force dut.sym_cnt_q = 16'hFFFF;
        mcnt = 16'hFFFF;
        step();
        release dut.sym_cnt_q;
        step();
        chk("c6_cnt_forced", 32'(sym_cnt), 32'hFFFF);
        run_syms(1);
        chk("c6_cnt_saturated", 32'(sym_cnt), 32'hFFFF);
`endif

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
